// File: rtl/div_sched_pkg.sv
// Shared types and constants for the div_sched divider scheduler.
package div_sched_pkg;

    localparam int DW = 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    typedef logic id_t;

    typedef logic [$clog2(DW)-1:0] cnt_t;

endpackage

// File: rtl/div_sched_if.sv
// Request/response bundle between the two ALU requesters, the result consumer and div_sched.
interface div_sched_if;
    import div_sched_pkg::*;

    logic            req0_valid;
    logic [DW-1:0]   req0_a;
    logic [DW-1:0]   req0_b;
    logic            req0_ready;

    logic            req1_valid;
    logic [DW-1:0]   req1_a;
    logic [DW-1:0]   req1_b;
    logic            req1_ready;

    logic            rsp_valid;
    logic            rsp_ready;
    id_t             rsp_id;
    logic [2*DW-1:0] rsp_quo;
    logic            rsp_dz;
    logic            busy;

    modport master (
        output req0_valid, req0_a, req0_b, input req0_ready,
        output req1_valid, req1_a, req1_b, input req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_quo, rsp_dz, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, output req0_ready,
        input  req1_valid, req1_a, req1_b, output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_quo, rsp_dz, busy
    );

endinterface

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_iter_step
    import div_sched_pkg::*;
(
    input  logic [DW:0]   r,
    input  logic          a_bit,
    input  logic [DW-1:0] b,
    output logic [DW:0]   r_next,
    output logic          q_bit
);

    logic [DW+1:0] r_shift;

    // The partial remainder stays below the divisor, so the 5-bit difference cannot overflow.
    assign r_shift = {r, a_bit};
    assign q_bit   = (r_shift >= {2'b00, b});
    assign r_next  = q_bit ? (r_shift[DW:0] - {1'b0, b}) : r_shift[DW:0];

endmodule

// File: rtl/div_sched.sv
// Two-port arbitrated 4-bit restoring divider returning {remainder, quotient}.
// Define DIV_SCHED_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module div_sched
    import div_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_sched_if.slave bus
);

    div_state_t      state;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [DW-1:0]   q_q;
    logic [DW-1:0]   q_next;
    logic [DW:0]     r_q;
    logic [DW:0]     step_r;
    logic            step_q;
    cnt_t            cnt;
    id_t             id_q;
    id_t             rsp_id_q;
    logic [2*DW-1:0] rsp_quo_q;
    logic            rsp_dz_q;

    logic            prio0;
    logic            grant0;
    logic            grant1;
    logic            accept;
    id_t             acc_id;
    logic [DW-1:0]   acc_a;
    logic [DW-1:0]   acc_b;

`ifdef DIV_SCHED_RR_EN
    id_t last_q;

    // Port 0 has priority exactly when port 1 was served last.
    assign prio0 = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= acc_id;
        end
    end
`else
    assign prio0 = 1'b1;
`endif

    assign grant0 = bus.req0_valid && (prio0 || !bus.req1_valid);
    assign grant1 = bus.req1_valid && !grant0;

    assign bus.req0_ready = (state == IDLE) && grant0;
    assign bus.req1_ready = (state == IDLE) && grant1;

    assign accept = bus.req0_ready || bus.req1_ready;
    assign acc_id = grant1;
    assign acc_a  = grant1 ? bus.req1_a : bus.req0_a;
    assign acc_b  = grant1 ? bus.req1_b : bus.req0_b;

    div_iter_step u_step (
        .r      (r_q),
        .a_bit  (a_q[cnt]),
        .b      (b_q),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    // NOTE: assign a default before the indexed update so no latch is inferred.
    always_comb begin
        q_next      = q_q;
        q_next[cnt] = step_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    // NOTE: operand and iteration registers are not reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_id_q  <= 1'b0;
            rsp_quo_q <= '0;
            rsp_dz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= acc_a;
                        b_q  <= acc_b;
                        id_q <= acc_id;
                        r_q  <= '0;
                        q_q  <= '0;
                        cnt  <= cnt_t'(DW - 1);
                        if (acc_b == '0) begin
                            rsp_quo_q <= '0;
                            rsp_dz_q  <= 1'b1;
                            rsp_id_q  <= acc_id;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q <= step_r;
                    q_q <= q_next;
                    if (cnt == '0) begin
                        rsp_quo_q <= {step_r[DW-1:0], q_next};
                        rsp_dz_q  <= 1'b0;
                        rsp_id_q  <= id_q;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_quo   = rsp_quo_q;
    assign bus.rsp_dz    = rsp_dz_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: vector table, arbitration, back-pressure, mid-op reset, full sweep.
module tb_div_sched;
    import div_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div_sched_if bus ();

    div_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] quo;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int port, input logic v, input logic [3:0] a, input logic [3:0] b);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Issue one request, wait for the handshake, then for the response; returns its fields.
    task automatic run_txn(input int port, input logic [3:0] a, input logic [3:0] b,
                           output logic [7:0] quo, output logic dz, output logic id, output int lat);
        bit ok;
        drive_req(port, 1'b1, a, b);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("req_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        drive_req(port, 1'b0, ~a, ~b);
        lat = 0;
        ok  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("rsp_valid_timeout", 0, 1);
        quo = bus.rsp_quo;
        dz  = bus.rsp_dz;
        id  = bus.rsp_id;
    endtask

    initial begin
        logic [7:0] quo;
        logic [7:0] exp_quo;
        logic       dz;
        logic       id;
        int         lat;
        int         n_rsp;
        int         seen;
        int         t_rsp[4];
        logic       ids[4];
        logic [7:0] quos[4];
        logic       exp_id1;
        bit         ok;

        vecs[0] = '{0, 4'd13, 4'd3,  8'h14, 1'b0, 5};
        vecs[1] = '{1, 4'd7,  4'd0,  8'h00, 1'b1, 1};
        vecs[2] = '{0, 4'd15, 4'd1,  8'h0F, 1'b0, 5};
        vecs[3] = '{1, 4'd9,  4'd4,  8'h12, 1'b0, 5};
        vecs[4] = '{0, 4'd14, 4'd5,  8'h42, 1'b0, 5};
        vecs[5] = '{1, 4'd0,  4'd7,  8'h00, 1'b0, 5};
        vecs[6] = '{0, 4'd15, 4'd15, 8'h01, 1'b0, 5};
        vecs[7] = '{1, 4'd1,  4'd15, 8'h10, 1'b0, 5};
        vecs[8] = '{0, 4'd15, 4'd2,  8'h17, 1'b0, 5};
        vecs[9] = '{1, 4'd0,  4'd0,  8'h00, 1'b1, 1};

        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive_req(0, 1'b0, 4'd0, 4'd0);
        drive_req(1, 1'b0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.rsp_valid, bus.busy, bus.rsp_dz, bus.rsp_id, bus.rsp_quo}, 12'h000);
        rst = 1'b0;
        @(negedge clk);
        drive_req(1, 1'b1, 4'd7, 4'd0);
        #1;
        check("ready_after_reset", {bus.req0_ready, bus.req1_ready}, 2'b01);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].port, vecs[i].a, vecs[i].b, quo, dz, id, lat);
            check($sformatf("vec%0d_quo", i), quo, vecs[i].quo);
            check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
            check($sformatf("vec%0d_id", i), id, vecs[i].port[0]);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Both ports held valid: fixed priority starves port 1, round-robin alternates.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_req(0, 1'b1, 4'd15, 4'd1);
        drive_req(1, 1'b1, 4'd9, 4'd4);
        n_rsp = 0;
        for (int c = 0; c < 100 && n_rsp < 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                t_rsp[n_rsp] = c;
                ids[n_rsp]   = bus.rsp_id;
                quos[n_rsp]  = bus.rsp_quo;
                n_rsp++;
            end
        end
        drive_req(0, 1'b0, 4'd0, 4'd0);
        drive_req(1, 1'b0, 4'd0, 4'd0);
        check("arb_count", n_rsp, 4);
`ifdef DIV_SCHED_RR_EN
        exp_id1 = 1'b1;
`else
        exp_id1 = 1'b0;
`endif
        for (int k = 0; k < 4 && k < n_rsp; k++) begin
            logic ek;
            ek = (k % 2 == 1) ? exp_id1 : 1'b0;
            check($sformatf("arb%0d_id", k), ids[k], ek);
            check($sformatf("arb%0d_quo", k), quos[k], ek ? 8'h12 : 8'h0F);
            if (k > 0) check($sformatf("arb%0d_period", k), t_rsp[k] - t_rsp[k-1], 6);
        end

        // Back-pressure: result and busy held, readies low while rsp_ready=0.
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        run_txn(0, 4'd14, 4'd5, quo, dz, id, lat);
        check("hold_first_quo", quo, 8'h42);
        drive_req(1, 1'b1, 4'd11, 4'd2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d", c),
                  {bus.rsp_valid, bus.rsp_quo, bus.rsp_id, bus.rsp_dz, bus.busy, bus.req0_ready, bus.req1_ready},
                  {1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_idle", {bus.busy, bus.rsp_valid, bus.req1_ready}, 3'b001);
        @(posedge clk);
        #1;
        drive_req(1, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        check("release_accepted", bus.busy, 1'b1);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("release_rsp_seen", ok, 1'b1);
        check("release_rsp", {bus.rsp_quo, bus.rsp_id, bus.rsp_dz}, {8'h15, 1'b1, 1'b0});

        // Reset during the second CALC cycle discards the operation.
        drive_req(0, 1'b1, 4'd13, 4'd3);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                ok = 1;
                break;
            end
        end
        check("rst_req_ready", ok, 1'b1);
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 4'd0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midop_reset", {bus.rsp_valid, bus.busy, bus.rsp_dz, bus.rsp_id, bus.rsp_quo, bus.req0_ready, bus.req1_ready}, 14'h0000);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("midop_no_rsp", seen, 0);
        run_txn(0, 4'd6, 4'd6, quo, dz, id, lat);
        check("after_reset_6_6", {quo, dz, id, lat[7:0]}, {8'h01, 1'b0, 1'b0, 8'd5});

        // Exhaustive sweep over all operand pairs, alternating ports.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int p;
                p = (a * 16 + b) % 2;
                run_txn(p, 4'(a), 4'(b), quo, dz, id, lat);
                exp_quo = (b == 0) ? 8'h00 : {4'(a % b), 4'(a / b)};
                check($sformatf("sweep_%0d_%0d", a, b), {lat[7:0], id, dz, quo},
                      {((b == 0) ? 8'd1 : 8'd5), 1'(p), (b == 0), exp_quo});
            end
        end

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_sched.md
# div_sched

Shared multi-cycle divider scheduler for the 4-bit custom ALU. It arbitrates between two requesters and runs one 4-bit unsigned restoring division at a time, one quotient bit per cycle. It returns the result packed as {remainder, quotient}, the ALU's divide result format. Divide-by-zero is short-circuited and flagged.

## Interface
Parameters:
- none; operand width is fixed at 4 by the package constant `DW`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  port 0 request
- `req0_a`, `req0_b`  in  4 each  port 0 dividend and divisor
- `req0_ready`  out  1  port 0 accepted when valid && ready
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`  same as port 0, for port 1
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  port that issued the result
- `rsp_quo`  out  8  {remainder[3:0], quotient[3:0]}
- `rsp_dz`  out  1  divisor was zero
- `busy`  out  1  state != IDLE

## Operation
- FSM states: `IDLE`, `CALC`, `DONE`.
- `IDLE`:
  - Grant is chosen combinationally. Only the granted port sees ready=1; the other port's ready is 0.
  - On handshake, latch A, B and id; clear R (5 bits) and Q (4 bits); set cnt=3.
  - If B==0, go to `DONE` with rsp_quo=8'h00 and rsp_dz=1.
  - Otherwise go to `CALC`.
- `CALC` (exactly 4 cycles, cnt 3 down to 0), each cycle:
  - R' = {R[3:0], A[cnt]}.
  - If R' >= {1'b0, B}: R = R' − B and Q[cnt] = 1.
  - Otherwise: R = R' and Q[cnt] = 0.
  - After cnt==0, go to `DONE`. rsp_quo={R[3:0], Q} and rsp_dz=0 are registered on that transition.
- `DONE`:
  - rsp_valid=1. rsp_quo, rsp_id and rsp_dz are held stable while rsp_ready=0.
  - On rsp_ready=1, go to `IDLE`.
- Both ready outputs are 0 in `CALC` and `DONE`. Requests wait; there is no queue.
- Arbitration (default, fixed priority): port 0 wins when both ports are valid.
- Results must equal A/B and A%B for every B≠0.

## Timing
- Reset values:
  - state=`IDLE`
  - rsp_valid=0, rsp_id=0, rsp_quo=8'h00, rsp_dz=0
  - busy=0
  - RR pointer=1 (when compiled in)
  - req0_ready and req1_ready follow IDLE grant logic and go high in the first cycle after reset if the port is valid.
- Latency, with the request handshake at edge t:
  - B≠0: rsp_valid=1 from edge t+5.
  - B==0: rsp_valid=1 from edge t+1.
- Response handshake at edge u: `IDLE` from edge u; the next request can be accepted at edge u+1.
  - Throughput is 1 result per 6 cycles (B≠0) with rsp_ready held high.
- Reset asserted in any state takes effect at the next edge. The in-flight operation is discarded and no response is produced for it.
- A request that drops valid before its ready is legal. Inputs are sampled only at the handshake; later changes to a/b do not affect the result.

## Configuration
- `DIV_SCHED_RR_EN` defined:
  - Round-robin arbitration using a 1-bit last-served pointer.
  - When both ports are valid, the grant goes to the port not served last.
  - The pointer updates on every accepted request.
  - The pointer resets to 1, so port 0 wins first.
- Undefined: fixed priority to port 0, and no pointer flop exists.

## Structure
- `div_sched_pkg`:
  - `DW`=4
  - state enum `div_state_t` {IDLE, CALC, DONE}
  - `id_t` (1 bit)
- Sub-module `div_iter_step`: combinational single restoring step.
  - Inputs: R[4:0], dividend bit, B.
  - Outputs: next R, q bit.
- `div_sched` holds the FSM, arbitration, counter and operand/result registers.

## Test plan
- Port 0 sends A=13, B=3 with rsp_ready=1 -> rsp_valid exactly 5 cycles after the handshake, rsp_quo=8'h14, rsp_id=0, rsp_dz=0.
- Port 1 sends A=7, B=0 -> rsp_valid next cycle, rsp_quo=8'h00, rsp_dz=1, rsp_id=1.
- Both ports valid and held (port 0: 15/1, port 1: 9/4):
  - Fixed priority -> results in order 8'h0F (id 0), then port 0 repeatedly starves port 1.
  - With `DIV_SCHED_RR_EN` -> 8'h0F (id 0), then 8'h12 (id 1), alternating.
- rsp_ready held 0 for 10 cycles after a 14/5 result -> rsp_quo stays 8'h42, busy=1, both ready outputs 0. Then rsp_ready=1 -> `IDLE` and a new request is accepted one cycle later.
- rst asserted during the 2nd `CALC` cycle -> all outputs at reset values the next cycle and no response is produced. A following 6/6 returns 8'h01.
- Exhaustive sweep of all 256 (A, B) pairs through alternating ports -> every response matches A/B and A%B, with dz set only when B=0.
